// File: rtl/uart_echo_responder_if.sv
`default_nettype none
// ============================================================================
//  Module   : uart_echo_responder_if
//  Purpose  : Parallel-side bundle between uart_rx / uart_tx and the echo
//             responder (receive strobe, transmit handshake, status).
//  Revision : 1.0  initial release
// ============================================================================
interface uart_echo_responder_if #(
  parameter int FIFO_AW = 4
);
  logic [7:0]       i_RxByte;
  logic             i_RxDone;
  logic             o_TxValid;
  logic [7:0]       o_TxByte;
  logic             i_TxDone;
  logic [FIFO_AW:0] o_Count;
  logic             o_Overflow;
  logic             o_Busy;

  // Responder side: consumes rx strobes and tx completion, drives tx and status
  modport slave (
    input  i_RxByte, i_RxDone, i_TxDone,
    output o_TxValid, o_TxByte, o_Count, o_Overflow, o_Busy
  );

  // Link side: uart_rx / uart_tx (or a bench standing in for them)
  modport master (
    output i_RxByte, i_RxDone, i_TxDone,
    input  o_TxValid, o_TxByte, o_Count, o_Overflow, o_Busy
  );
endinterface
`default_nettype wire

// File: rtl/uart_echo_responder.sv
`default_nettype none
// ============================================================================
//  Module   : uart_echo_responder
//  Purpose  : Far-end loopback. Buffers bytes from uart_rx in a circular FIFO
//             and replays them, in order, through uart_tx.
//  Revision : 1.0  initial release
// ============================================================================
module uart_echo_responder #(
  parameter int FIFO_AW = 4
) (
  input  wire logic            i_SysClock,
  input  wire logic            i_Reset,
  uart_echo_responder_if.slave bus
);

  localparam int               DEPTH  = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] C_FULL = {1'b1, {FIFO_AW{1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_nextState;
  logic [7:0]         r_mem [DEPTH];
  logic [FIFO_AW-1:0] r_wrPtr;
  logic [FIFO_AW-1:0] r_rdPtr;
  logic [FIFO_AW:0]   r_count;
  logic [7:0]         r_txByte;
  logic               r_overflow;

  logic w_full;
  logic w_pop;
  logic w_push;
  logic w_drop;

  // A pop frees a slot on the same edge, so a full FIFO can still accept a
  // byte when the FSM is about to launch the next frame.
  assign w_full = (r_count == C_FULL);
  assign w_pop  = (r_state == ST_IDLE) && (r_count != '0);
  assign w_push = bus.i_RxDone && (!w_full || w_pop);
  assign w_drop = bus.i_RxDone && w_full && !w_pop;

  // State register
  always_ff @(posedge i_SysClock) begin
    if (i_Reset) r_state <= ST_IDLE;
    else         r_state <= w_nextState;
  end

  // Next-state: launch on a non-empty FIFO, strobe for one cycle, wait for tx
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE:  if (r_count != '0) w_nextState = ST_START;
      ST_START: w_nextState = ST_WAIT;
      ST_WAIT:  if (bus.i_TxDone) w_nextState = ST_IDLE;
      default:  w_nextState = ST_IDLE;
    endcase
  end

  // FIFO storage; contents need no reset because the pointers define validity
  always_ff @(posedge i_SysClock) begin
    if (!i_Reset && w_push) r_mem[r_wrPtr] <= bus.i_RxByte;
  end

  // Pointers, occupancy, transmit byte latch and sticky overflow flag
  always_ff @(posedge i_SysClock) begin
    if (i_Reset) begin
      r_wrPtr    <= '0;
      r_rdPtr    <= '0;
      r_count    <= '0;
      r_txByte   <= 8'h00;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_pop) begin
        r_rdPtr  <= r_rdPtr + 1'b1;
        r_txByte <= r_mem[r_rdPtr];
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  assign bus.o_TxValid  = (r_state == ST_START);
  assign bus.o_TxByte   = r_txByte;
  assign bus.o_Count    = r_count;
  assign bus.o_Overflow = r_overflow;
  assign bus.o_Busy     = (r_state != ST_IDLE) || (r_count != '0);

endmodule
`default_nettype wire

// File: tb/tb_uart_echo_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_echo_responder
//  Purpose  : Directed self-checking bench for uart_echo_responder with a
//             simple uart_tx stand-in (fixed frame length, can be stalled).
//  Revision : 1.0  initial release
// ============================================================================
module tb_uart_echo_responder;

  logic clk;
  logic rst;
  logic manualDone;
  logic modelDone;
  logic modelHold;
  int   frameLen;
  int   countdown;
  int   cyc;
  int   vectors;
  int   miscompares;
  logic [7:0] echoQ[$];
  int         validCyc[$];

  uart_echo_responder_if #(.FIFO_AW(4)) bus ();

  uart_echo_responder #(.FIFO_AW(4)) dut (
    .i_SysClock (clk),
    .i_Reset    (rst),
    .bus        (bus)
  );

  assign bus.i_TxDone = manualDone | modelDone;

  // Clock generation
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Cycle counter
  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // uart_tx stand-in: records each echo, raises done frameLen cycles later
  initial begin
    modelDone = 1'b0;
    countdown = 0;
    forever begin
      @(negedge clk);
      modelDone = 1'b0;
      if (bus.o_TxValid) begin
        echoQ.push_back(bus.o_TxByte);
        validCyc.push_back(cyc);
        countdown = frameLen;
      end else if (!bus.o_Busy) begin
        countdown = 0;
      end else if (countdown > 0 && !modelHold) begin
        countdown--;
        if (countdown == 0) modelDone = 1'b1;
      end
    end
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required finish");
    $fatal(1);
  end

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic doReset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic pushByte(input logic [7:0] b);
    bus.i_RxByte = b;
    bus.i_RxDone = 1'b1;
    @(negedge clk);
    bus.i_RxDone = 1'b0;
  endtask

  task automatic pulseDone();
    manualDone = 1'b1;
    @(negedge clk);
    manualDone = 1'b0;
  endtask

  task automatic checkResetVals(input string tag);
    checkVal({tag, "_count"},    32'(bus.o_Count),    32'd0);
    checkVal({tag, "_txvalid"},  32'(bus.o_TxValid),  32'd0);
    checkVal({tag, "_txbyte"},   32'(bus.o_TxByte),   32'h00);
    checkVal({tag, "_overflow"}, 32'(bus.o_Overflow), 32'd0);
    checkVal({tag, "_busy"},     32'(bus.o_Busy),     32'd0);
  endtask

  task automatic waitIdle(input string tag, input int limit);
    int n;
    n = 0;
    while (bus.o_Busy && n < limit) begin
      @(negedge clk);
      n++;
    end
    tick(2);
    checkVal({tag, "_idle_timeout"}, 32'(bus.o_Busy), 32'd0);
  endtask

  // Directed stimulus
  initial begin
    int peak;
    int startSize;
    vectors      = 0;
    miscompares  = 0;
    rst          = 1'b1;
    manualDone   = 1'b0;
    modelHold    = 1'b1;
    frameLen     = 10;
    bus.i_RxByte = 8'h00;
    bus.i_RxDone = 1'b0;
    tick(3);
    rst = 1'b0;
    checkResetVals("reset");

    // Single byte, manual completion
    pushByte(8'hA5);
    checkVal("single_count_n1", 32'(bus.o_Count), 32'd1);
    checkVal("single_valid_n1", 32'(bus.o_TxValid), 32'd0);
    tick(1);
    checkVal("single_valid_n2", 32'(bus.o_TxValid), 32'd1);
    checkVal("single_byte_n2",  32'(bus.o_TxByte),  32'hA5);
    tick(1);
    checkVal("single_valid_off", 32'(bus.o_TxValid), 32'd0);
    checkVal("single_busy_wait", 32'(bus.o_Busy),    32'd1);
    tick(5);
    checkVal("single_byte_hold", 32'(bus.o_TxByte), 32'hA5);
    pulseDone();
    checkVal("single_busy_drop", 32'(bus.o_Busy), 32'd0);

    // Burst ordering with a 10-cycle frame
    echoQ.delete();
    validCyc.delete();
    modelHold    = 1'b0;
    peak         = 0;
    bus.i_RxDone = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      bus.i_RxByte = 8'(i);
      @(negedge clk);
      if (int'(bus.o_Count) > peak) peak = int'(bus.o_Count);
    end
    bus.i_RxDone = 1'b0;
    for (int i = 0; i < 60 && bus.o_Busy; i++) begin
      if (int'(bus.o_Count) > peak) peak = int'(bus.o_Count);
      @(negedge clk);
    end
    waitIdle("burst", 100);
    checkVal("burst_n_echo", 32'(echoQ.size()), 32'd3);
    if (echoQ.size() == 3 && validCyc.size() == 3) begin
      checkVal("burst_echo0", 32'(echoQ[0]), 32'h01);
      checkVal("burst_echo1", 32'(echoQ[1]), 32'h02);
      checkVal("burst_echo2", 32'(echoQ[2]), 32'h03);
      checkVal("burst_gap01", 32'(validCyc[1] - validCyc[0]), 32'd12);
      checkVal("burst_gap12", 32'(validCyc[2] - validCyc[1]), 32'd12);
    end
    checkVal("burst_peak_count", 32'(peak), 32'd2);

    // Overflow while stalled in WAIT
    echoQ.delete();
    modelHold    = 1'b1;
    bus.i_RxDone = 1'b1;
    for (int i = 0; i < 18; i++) begin
      bus.i_RxByte = 8'(i);
      @(negedge clk);
    end
    bus.i_RxDone = 1'b0;
    checkVal("ovf_count_full", 32'(bus.o_Count),    32'd16);
    checkVal("ovf_flag_set",   32'(bus.o_Overflow), 32'd1);
    modelHold = 1'b0;
    waitIdle("ovf", 400);
    checkVal("ovf_n_echo", 32'(echoQ.size()), 32'd17);
    if (echoQ.size() == 17) begin
      for (int i = 0; i < 17; i++) checkVal($sformatf("ovf_echo%0d", i), 32'(echoQ[i]), 32'(i));
    end
    checkVal("ovf_flag_sticky", 32'(bus.o_Overflow), 32'd1);

    // Simultaneous push and pop at full
    doReset();
    checkResetVals("reset2");
    echoQ.delete();
    modelHold    = 1'b1;
    pushByte(8'hA0);
    bus.i_RxDone = 1'b1;
    for (int i = 0; i < 16; i++) begin
      bus.i_RxByte = 8'hB0 + 8'(i);
      @(negedge clk);
    end
    bus.i_RxDone = 1'b0;
    tick(2);
    checkVal("full_count_pre", 32'(bus.o_Count), 32'd16);
    manualDone = 1'b1;
    @(negedge clk);
    manualDone   = 1'b0;
    bus.i_RxByte = 8'h5A;
    bus.i_RxDone = 1'b1;
    @(negedge clk);
    bus.i_RxDone = 1'b0;
    checkVal("full_count_same", 32'(bus.o_Count),    32'd16);
    checkVal("full_no_overflow", 32'(bus.o_Overflow), 32'd0);
    checkVal("full_pop_valid",  32'(bus.o_TxValid),  32'd1);
    checkVal("full_pop_byte",   32'(bus.o_TxByte),   32'hB0);
    modelHold = 1'b0;
    waitIdle("full", 400);
    checkVal("full_n_echo", 32'(echoQ.size()), 32'd18);
    if (echoQ.size() == 18) begin
      checkVal("full_echo_last", 32'(echoQ[17]), 32'h5A);
      checkVal("full_echo_bf",   32'(echoQ[16]), 32'hBF);
    end

    // Reset while waiting with three bytes queued
    modelHold = 1'b1;
    pushByte(8'h11);
    bus.i_RxDone = 1'b1;
    bus.i_RxByte = 8'h22;
    @(negedge clk);
    bus.i_RxByte = 8'h33;
    @(negedge clk);
    bus.i_RxByte = 8'h44;
    @(negedge clk);
    bus.i_RxDone = 1'b0;
    checkVal("midrst_count_pre", 32'(bus.o_Count), 32'd3);
    doReset();
    checkResetVals("midrst");
    startSize = echoQ.size();
    modelHold = 1'b0;
    tick(40);
    checkVal("midrst_no_echo", 32'(echoQ.size() - startSize), 32'd0);
    checkVal("midrst_idle",    32'(bus.o_Busy), 32'd0);

    // Spurious done in IDLE, then a normal echo that waits for done
    modelHold = 1'b1;
    pulseDone();
    checkVal("spur_busy",  32'(bus.o_Busy),    32'd0);
    checkVal("spur_valid", 32'(bus.o_TxValid), 32'd0);
    pushByte(8'h3C);
    checkVal("spur_count", 32'(bus.o_Count), 32'd1);
    tick(1);
    checkVal("spur_echo_valid", 32'(bus.o_TxValid), 32'd1);
    checkVal("spur_echo_byte",  32'(bus.o_TxByte),  32'h3C);
    tick(30);
    checkVal("spur_still_wait", 32'(bus.o_Busy),    32'd1);
    checkVal("spur_no_restrobe", 32'(bus.o_TxValid), 32'd0);
    pulseDone();
    checkVal("spur_done_idle", 32'(bus.o_Busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_echo_responder.md
# uart_echo_responder

Far-end loopback responder for the UART link. Consumes received bytes from a `uart_rx` instance, buffers them in an internal FIFO, and replays each byte through a `uart_tx` instance in arrival order. The block closes the serial loop so that a host or bench can send bytes and check that the identical stream comes back. It sits between the `uart_rx` parallel outputs and the `uart_tx` parallel inputs, and runs on the same system clock.

## Interface
- `FIFO_AW`, default 4: FIFO address width; depth = 2**FIFO_AW (16 by default).
- `i_SysClock`, input, 1: system clock; all logic is on the rising edge.
- `i_Reset`, input, 1: **synchronous, active-high** reset.
- `i_RxByte`, input, 8: received byte from `uart_rx`; valid in the cycle where `i_RxDone`=1.
- `i_RxDone`, input, 1: one-cycle strobe marking a received byte.
- `o_TxValid`, output, 1: one-cycle start strobe to `uart_tx`.
- `o_TxByte`, output, 8: byte to transmit; registered and held stable from the `o_TxValid` cycle until `i_TxDone`.
- `i_TxDone`, input, 1: one-cycle strobe from `uart_tx` at the end of its stop bit.
- `o_Count`, output, FIFO_AW+1: current FIFO occupancy, range 0..2**FIFO_AW.
- `o_Overflow`, output, 1: sticky flag; a received byte was dropped because the FIFO was full.
- `o_Busy`, output, 1: high when the state is not IDLE or `o_Count`≠0.

## Operation
- The FIFO is circular, with write pointer, read pointer and a separate occupancy counter. Pointers are FIFO_AW bits and wrap modulo the depth.
- **Push:** occurs on the edge where `i_RxDone`=1 and the FIFO is not full, or where it is full but a pop happens on the same edge.
- **Pop:** occurs on the edge where the FSM is in IDLE and `o_Count`≠0. `o_TxByte` is loaded from the FIFO head on that edge.
- **Simultaneous push and pop:** both take effect and `o_Count` is unchanged. This holds even when the FIFO is full or when `o_Count`=1. The pushed byte goes to the write pointer and the popped byte comes from the old head.
- **Overflow:** a push request while full with no pop on that edge drops the byte. Pointers and count are unchanged, and `o_Overflow` is set and held until reset.
- **FSM states:** IDLE, START, WAIT.
  - IDLE: if `o_Count`≠0, pop and go to START; otherwise stay in IDLE.
  - START: `o_TxValid`=1 for exactly this cycle, then unconditionally go to WAIT.
  - WAIT: on `i_TxDone`=1 go to IDLE; otherwise stay in WAIT.
- `i_TxDone` is ignored in IDLE and START.
- `i_RxDone` is accepted in every state. Reception and transmission are independent.
- Bytes are echoed unmodified and in FIFO order.

## Timing
- **Reset values** (at the edge where `i_Reset`=1):
  - state IDLE, pointers 0;
  - `o_Count`=0, `o_TxValid`=0, `o_TxByte`=8'h00, `o_Overflow`=0, `o_Busy`=0.
- Reset takes priority over all other inputs at that edge.
- **Reset mid-operation:** FIFO contents are discarded and the FSM returns to IDLE. This block does not abort a `uart_tx` frame already in flight; the system resets both instances together.
- **Empty-FIFO latency:** `i_RxDone` high in cycle N gives `o_Count`=1 in cycle N+1 (the pop also occurs at the end of N+1). `o_TxValid` is high in cycle N+2.
- **Back-to-back:** `i_TxDone` high in cycle T gives IDLE in T+1 (pop at the end of T+1) and `o_TxValid` in T+2. Minimum spacing between `o_TxValid` pulses is therefore frame length + 2 cycles.
- `o_TxValid` is never high for more than one consecutive cycle.
- `o_TxByte` changes only on a pop edge.
- `o_Count` reflects pushes and pops one cycle after the strobe edge.
- `o_Busy` is combinational from registered state and count.

## Test plan
- **Single byte:** reset, then `i_RxDone` with `i_RxByte`=8'hA5.
  - Required: `o_TxValid` high exactly 2 cycles later with `o_TxByte`=8'hA5.
  - `o_TxByte` holds until `i_TxDone`; `o_Busy` drops the cycle after `i_TxDone`.
- **Burst ordering:** strobe 8'h01, 8'h02, 8'h03 on consecutive cycles while the bench models `uart_tx` with a 10-cycle frame.
  - Required: echoes are 01, 02, 03 in order, `o_TxValid` pulses spaced 12 cycles apart, and `o_Count` peaks at 2.
- **Overflow:** hold `i_TxDone` low (stall in WAIT) and push 18 bytes 8'h00..8'h11.
  - Required: the first byte is already popped, so 8'h01..8'h10 fill the FIFO; `o_Count`=16.
  - 8'h11 is dropped and `o_Overflow`=1.
  - After `i_TxDone` is released, the echoes are 00..10 and `o_Overflow` stays 1.
- **Push and pop on the same edge at full:** with the FIFO full and the FSM in IDLE, strobe `i_RxDone`=8'h5A.
  - Required: `o_Count` stays 16, no overflow, and 8'h5A is echoed last.
- **Reset mid-WAIT:** with 3 bytes queued and the FSM in WAIT, assert `i_Reset` for 1 cycle.
  - Required: all outputs at reset values next cycle, and no further `o_TxValid` until a new `i_RxDone`.
- **Spurious done:** pulse `i_TxDone` while in IDLE with the FIFO empty, then push 8'h3C.
  - Required: no state change from the spurious pulse; 8'h3C is echoed normally and the FSM stays in WAIT until the next `i_TxDone`.
